// File: rtl/rate_ce_scheduler.sv
// rate_ce_scheduler: fractional num/den clock-enable strobe generator with run/stop and config handshake.
// Optional strobe counter on ce_count enabled by defining RATE_CE_COUNT_EN.
module rate_ce_scheduler #(
  parameter int ACC_W   = 8,
  parameter int DEF_NUM = 2,
  parameter int DEF_DEN = 3
) (
  input  logic             clk_9MHz,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             ce_out,
  output logic [ACC_W-1:0] phase,
  output logic [15:0]      ce_count
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, num, den, acc_nx;
  logic [ACC_W:0] sum;
  logic hit, cfg_take, cfg_ok, stop_pend;
  assign sum       = {1'b0, acc} + {1'b0, num};
  assign hit       = sum >= {1'b0, den};
  assign acc_nx    = hit ? ACC_W'(sum - {1'b0, den}) : sum[ACC_W-1:0];
  assign cfg_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign phase     = acc;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_ok    = cfg_den != '0 && cfg_num != '0 && cfg_num <= cfg_den;
  // The stop cycle itself accumulates, so a zero result there ends the run at once.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = (start && !stop) ? RUN : IDLE;
      RUN:      state_nx = stop ? ((acc_nx == '0) ? IDLE : STOPPING) : RUN;
      STOPPING: state_nx = (stop_pend && acc_nx == '0) ? IDLE : STOPPING;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_9MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      num       <= ACC_W'(DEF_NUM);
      den       <= ACC_W'(DEF_DEN);
      stop_pend <= 1'b0;
      ce_out    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg_err <= cfg_take && !cfg_ok;
      if (cfg_take && cfg_ok) begin
        num <= cfg_num;
        den <= cfg_den;
      end
      if (state == IDLE) begin
        ce_out    <= 1'b0;
        stop_pend <= 1'b0;
        if (state_nx == RUN) acc <= '0;
      end else begin
        acc       <= acc_nx;
        ce_out    <= hit;
        stop_pend <= state_nx == STOPPING;
      end
    end
  end
`ifdef RATE_CE_COUNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk_9MHz or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (state == IDLE && state_nx == RUN) cnt <= '0;
    else if (ce_out && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign ce_count = cnt;
`else
  assign ce_count = '0;
`endif
endmodule

// File: tb/tb_rate_ce_scheduler.sv
// tb_rate_ce_scheduler: directed self-checking bench for rate_ce_scheduler.
module tb_rate_ce_scheduler;
  logic clk_9MHz = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic [7:0] cfg_num = '0, cfg_den = '0;
  logic start = 1'b0, stop = 1'b0;
  logic cfg_ready, cfg_err, busy, ce_out;
  logic [7:0] phase;
  logic [15:0] ce_count;
  int checks = 0;
  int errors = 0;

  rate_ce_scheduler dut (
    .clk_9MHz(clk_9MHz), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_num(cfg_num),
    .cfg_den(cfg_den), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .start(start),
    .stop(stop), .busy(busy), .ce_out(ce_out), .phase(phase), .ce_count(ce_count)
  );

  always #5 clk_9MHz = ~clk_9MHz;

  task automatic stop_run;
    int n;
    stop = 1'b1;
    @(negedge clk_9MHz);
    stop = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk_9MHz);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_timeout busy got %b exp 0", busy); end
    @(negedge clk_9MHz);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk_9MHz);
    checks++;
    if ({ce_out, busy, cfg_ready, cfg_err} !== 4'b0010) begin
      errors++; $display("FAIL reset_flags got %b exp 0010", {ce_out, busy, cfg_ready, cfg_err});
    end
    checks++;
    if (phase !== 8'd0 || ce_count !== 16'd0) begin
      errors++; $display("FAIL reset_phase_count got %0d/%0d exp 0/0", phase, ce_count);
    end
    rst_n = 1'b1;
    @(negedge clk_9MHz);
  endtask

  task automatic test_default;
    int ones;
    logic exp_ce;
    logic [7:0] exp_ph;
    start = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || phase !== 8'd0 || ce_out !== 1'b0) begin
      errors++; $display("FAIL default_enter got busy=%b phase=%0d ce=%b exp 1/0/0", busy, phase, ce_out);
    end
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_9MHz);
      exp_ce = (i % 3) != 0;
      exp_ph = 8'(2 - (i % 3));
      checks++;
      if (ce_out !== exp_ce) begin errors++; $display("FAIL default_ce[%0d] got %b exp %b", i, ce_out, exp_ce); end
      checks++;
      if (phase !== exp_ph) begin errors++; $display("FAIL default_phase[%0d] got %0d exp %0d", i, phase, exp_ph); end
      ones += int'(ce_out);
    end
    checks++;
    if (ones != 20) begin errors++; $display("FAIL default_ones got %0d exp 20", ones); end
`ifdef RATE_CE_COUNT_EN
    checks++;
    if (ce_count !== 16'd19) begin errors++; $display("FAIL default_count got %0d exp 19", ce_count); end
`else
    checks++;
    if (ce_count !== 16'd0) begin errors++; $display("FAIL count_tied got %0d exp 0", ce_count); end
`endif
  endtask

  task automatic test_stop;
    @(negedge clk_9MHz);
    checks++;
    if (phase !== 8'd2) begin errors++; $display("FAIL stop_pre_phase got %0d exp 2", phase); end
    stop = 1'b1;
    @(negedge clk_9MHz);
    stop = 1'b0;
    checks++;
    if ({ce_out, busy} !== 2'b11 || phase !== 8'd1) begin
      errors++; $display("FAIL stop_step1 got ce,busy=%b phase=%0d exp 11/1", {ce_out, busy}, phase);
    end
    @(negedge clk_9MHz);
    checks++;
    if ({ce_out, busy} !== 2'b10 || phase !== 8'd0) begin
      errors++; $display("FAIL stop_final got ce,busy=%b phase=%0d exp 10/0", {ce_out, busy}, phase);
    end
    @(negedge clk_9MHz);
    checks++;
    if ({ce_out, busy, cfg_ready} !== 3'b001 || phase !== 8'd0) begin
      errors++; $display("FAIL stop_idle got %b phase=%0d exp 001/0", {ce_out, busy, cfg_ready}, phase);
    end
  endtask

  task automatic test_cfg;
    logic [3:0] pat;
    cfg_valid = 1'b1; cfg_num = 8'd5; cfg_den = 8'd4;
    @(negedge clk_9MHz);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse got %b exp 1", cfg_err); end
    @(negedge clk_9MHz);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_width got %b exp 0", cfg_err); end
    start = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_9MHz);
      checks++;
      if (phase !== 8'(2 - i)) begin errors++; $display("FAIL cfg_kept_phase[%0d] got %0d exp %0d", i, phase, 2 - i); end
    end
    stop_run();
    cfg_valid = 1'b1; cfg_num = 8'd3; cfg_den = 8'd4; start = 1'b1;
    @(negedge clk_9MHz);
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL cfg34_start got err=%b busy=%b exp 0/1", cfg_err, busy);
    end
    pat = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_9MHz);
      checks++;
      if (ce_out !== pat[i % 4]) begin errors++; $display("FAIL cfg34_ce[%0d] got %b exp %b", i, ce_out, pat[i % 4]); end
      checks++;
      if (phase !== 8'(3 - (i % 4))) begin
        errors++; $display("FAIL cfg34_phase[%0d] got %0d exp %0d", i, phase, 3 - (i % 4));
      end
    end
  endtask

  task automatic test_cfg_in_run;
    cfg_valid = 1'b1; cfg_num = 8'd5; cfg_den = 8'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_9MHz);
      checks++;
      if ({cfg_ready, cfg_err, busy} !== 3'b001) begin
        errors++; $display("FAIL run_cfg_ignored[%0d] got %b exp 001", i, {cfg_ready, cfg_err, busy});
      end
    end
    cfg_valid = 1'b0;
    stop_run();
  endtask

  task automatic test_start_stop_idle;
    start = 1'b1; stop = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy, ce_out} !== 2'b00) begin errors++; $display("FAIL start_stop_idle[%0d] got %b exp 00", i, {busy, ce_out}); end
      @(negedge clk_9MHz);
    end
  endtask

  task automatic test_async_reset;
    cfg_valid = 1'b1; cfg_num = 8'd1; cfg_den = 8'd5;
    @(negedge clk_9MHz);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0;
    repeat (5) @(negedge clk_9MHz);
    checks++;
    if (ce_out !== 1'b1 || phase !== 8'd0) begin
      errors++; $display("FAIL r15_strobe got ce=%b phase=%0d exp 1/0", ce_out, phase);
    end
    @(negedge clk_9MHz);
    checks++;
    if (phase !== 8'd1) begin errors++; $display("FAIL r15_phase got %0d exp 1", phase); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ce_out, busy, cfg_ready} !== 3'b001 || phase !== 8'd0) begin
      errors++; $display("FAIL async_reset got %b phase=%0d exp 001/0", {ce_out, busy, cfg_ready}, phase);
    end
    @(negedge clk_9MHz);
    rst_n = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_9MHz);
      checks++;
      if (ce_out !== ((i % 3) != 0)) begin
        errors++; $display("FAIL post_reset_ce[%0d] got %b exp %b", i, ce_out, (i % 3) != 0);
      end
    end
    stop_run();
  endtask

  task automatic test_count;
`ifdef RATE_CE_COUNT_EN
    cfg_valid = 1'b1; cfg_num = 8'd1; cfg_den = 8'd1;
    @(negedge clk_9MHz);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0;
    checks++;
    if (ce_count !== 16'd0) begin errors++; $display("FAIL count_clear got %0d exp 0", ce_count); end
    repeat (4) @(negedge clk_9MHz);
    checks++;
    if (ce_count !== 16'd3) begin errors++; $display("FAIL count_early got %0d exp 3", ce_count); end
    repeat (70000) @(negedge clk_9MHz);
    checks++;
    if (ce_count !== 16'hFFFF) begin errors++; $display("FAIL count_sat got %h exp ffff", ce_count); end
    stop_run();
    repeat (3) @(negedge clk_9MHz);
    checks++;
    if (ce_count !== 16'hFFFF) begin errors++; $display("FAIL count_hold got %h exp ffff", ce_count); end
`else
    start = 1'b1;
    @(negedge clk_9MHz);
    start = 1'b0;
    repeat (9) @(negedge clk_9MHz);
    checks++;
    if (ce_count !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL count_absent got %0d busy=%b exp 0/1", ce_count, busy);
    end
    stop_run();
`endif
  endtask

  initial begin
    test_reset();
    test_default();
    test_stop();
    test_cfg();
    test_cfg_in_run();
    test_start_stop_idle();
    test_async_reset();
    test_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
